// File: rtl/sha256_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_pkg : shared constants and state encoding for the SHA256 host side |
// | Revision   : 1.0                                                         |
// +--------------------------------------------------------------------------+
package sha256_pkg;

  localparam int SHA256_MSG_BYTES = 32;
  localparam int SHA256_DIGEST_W  = 256;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SEND     = 2'd1;
  localparam logic [1:0] GAP      = 2'd2;
  localparam logic [1:0] COMPLETE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE     = IDLE,
    S_SEND     = SEND,
    S_GAP      = GAP,
    S_COMPLETE = COMPLETE
  } state_e;

  typedef logic [SHA256_DIGEST_W-1:0] digest_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sha256_gap_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_gap_timer : loadable down-counter with a zero flag                 |
// | Revision         : 1.0                                                    |
// +--------------------------------------------------------------------------+
module sha256_gap_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_value,
  input  logic             i_dec,
  output logic             o_zero
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Load wins over decrement; the counter saturates at zero.
  always_comb begin
    count_d = count_q;
    if (i_load) begin
      count_d = i_value;
    end else if (i_dec && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_zero = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/sha256_byte_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sha256_byte_streamer : serializes a 256-bit message MSB-first into bytes |
// | for the SHA256 core loader, then raises input_complete.  Revision: 1.0   |
// +--------------------------------------------------------------------------+
module sha256_byte_streamer
  import sha256_pkg::*;
#(
  parameter int MSG_BYTES       = SHA256_MSG_BYTES,
  parameter int IDLE_GAP        = 0,
  parameter int COMPLETE_CYCLES = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   msg_valid,
  input  logic [8*MSG_BYTES-1:0] msg_data,
  output logic                   msg_ready,
  input  logic                   abort,
  output logic                   load_enable,
  output logic                   input_complete,
  output logic [7:0]             input_data,
  output logic                   busy,
  output logic                   done
);

  localparam int MSG_W = 8 * MSG_BYTES;
  localparam int CNT_W = $clog2(MSG_BYTES + 1);
  localparam int TMR_W = $clog2(max_int(IDLE_GAP, COMPLETE_CYCLES) + 1);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(MSG_BYTES - 1);
  localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);
  localparam logic [TMR_W-1:0] CPL_LOAD  = TMR_W'(COMPLETE_CYCLES - 1);

  state_e             state_q, state_d;
  logic [MSG_W-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic               msg_ready_q, msg_ready_d;
  logic               load_enable_q, load_enable_d;
  logic               input_complete_q, input_complete_d;
  logic [7:0]         input_data_q, input_data_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               tmr_load;
  logic [TMR_W-1:0]   tmr_value;
  logic               tmr_dec;
  logic               tmr_zero;
  logic               emit_next;

  sha256_gap_timer #(
    .WIDTH (TMR_W)
  ) u_dwell (
    .clk     (clock),
    .rst     (reset),
    .i_load  (tmr_load),
    .i_value (tmr_value),
    .i_dec   (tmr_dec),
    .o_zero  (tmr_zero)
  );

  // Outputs are registered, so each branch computes what the next cycle shows.
  // byte_cnt holds the index of the byte currently on input_data.
  always_comb begin
    state_d          = state_q;
    shreg_d          = shreg_q;
    byte_cnt_d       = byte_cnt_q;
    load_enable_d    = 1'b0;
    input_complete_d = 1'b0;
    input_data_d     = 8'h00;
    done_d           = 1'b0;
    tmr_load         = 1'b0;
    tmr_value        = '0;
    tmr_dec          = 1'b0;
    emit_next        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (msg_valid && msg_ready_q) begin
          state_d       = S_SEND;
          load_enable_d = 1'b1;
          input_data_d  = msg_data[MSG_W-1 -: 8];
          shreg_d       = {msg_data[MSG_W-9:0], 8'h00};
          byte_cnt_d    = '0;
        end
      end
      S_SEND: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (byte_cnt_q == LAST_BYTE) begin
          state_d          = S_COMPLETE;
          input_complete_d = 1'b1;
          tmr_load         = 1'b1;
          tmr_value        = CPL_LOAD;
        end else if (IDLE_GAP > 0) begin
          state_d   = S_GAP;
          tmr_load  = 1'b1;
          tmr_value = GAP_LOAD;
        end else begin
          emit_next = 1'b1;
        end
      end
      S_GAP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (tmr_zero) begin
          emit_next = 1'b1;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      S_COMPLETE: begin
        // The done cycle is the final cycle spent in COMPLETE.
        if (done_q) begin
          state_d = S_IDLE;
        end else if (tmr_zero) begin
          done_d = 1'b1;
        end else begin
          tmr_dec          = 1'b1;
          input_complete_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (emit_next) begin
      state_d       = S_SEND;
      load_enable_d = 1'b1;
      input_data_d  = shreg_q[MSG_W-1 -: 8];
      shreg_d       = {shreg_q[MSG_W-9:0], 8'h00};
      byte_cnt_d    = byte_cnt_q + CNT_W'(1);
    end

    msg_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      shreg_q          <= '0;
      byte_cnt_q       <= '0;
      msg_ready_q      <= 1'b0;
      load_enable_q    <= 1'b0;
      input_complete_q <= 1'b0;
      input_data_q     <= 8'h00;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
    end else begin
      state_q          <= state_d;
      shreg_q          <= shreg_d;
      byte_cnt_q       <= byte_cnt_d;
      msg_ready_q      <= msg_ready_d;
      load_enable_q    <= load_enable_d;
      input_complete_q <= input_complete_d;
      input_data_q     <= input_data_d;
      busy_q           <= busy_d;
      done_q           <= done_d;
    end
  end

  assign msg_ready      = msg_ready_q;
  assign load_enable    = load_enable_q;
  assign input_complete = input_complete_q;
  assign input_data     = input_data_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sha256_byte_streamer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sha256_byte_streamer : directed self-checking bench for the streamer  |
// | Revision                : 1.0                                            |
// +--------------------------------------------------------------------------+
module tb_sha256_byte_streamer;

  localparam int MSG_W = 256;

  logic clock = 1'b0;
  logic reset;

  logic             msg_valid, abort;
  logic [MSG_W-1:0] msg_data;
  logic             msg_ready, load_enable, input_complete, busy, done;
  logic [7:0]       input_data;

  logic             g_valid, g_abort;
  logic [MSG_W-1:0] g_data;
  logic             g_ready, g_le, g_ic, g_busy, g_done;
  logic [7:0]       g_idata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  sha256_byte_streamer dut (
    .clock          (clock),
    .reset          (reset),
    .msg_valid      (msg_valid),
    .msg_data       (msg_data),
    .msg_ready      (msg_ready),
    .abort          (abort),
    .load_enable    (load_enable),
    .input_complete (input_complete),
    .input_data     (input_data),
    .busy           (busy),
    .done           (done)
  );

  sha256_byte_streamer #(
    .IDLE_GAP (2)
  ) dut_gap (
    .clock          (clock),
    .reset          (reset),
    .msg_valid      (g_valid),
    .msg_data       (g_data),
    .msg_ready      (g_ready),
    .abort          (g_abort),
    .load_enable    (g_le),
    .input_complete (g_ic),
    .input_data     (g_idata),
    .busy           (g_busy),
    .done           (g_done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MSG_W-1:0] ramp(input logic [7:0] base);
    logic [MSG_W-1:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) r[MSG_W-1-8*i -: 8] = base + 8'(i);
    return r;
  endfunction

  initial begin
    int bad, ov, le_cnt, ic_cnt, done_cnt, done_at, first_b;
    logic [7:0] bytes[$];
    logic exp_le, exp_ic, exp_done;

    reset = 1'b1; msg_valid = 1'b0; abort = 1'b0; msg_data = '0;
    g_valid = 1'b0; g_abort = 1'b0; g_data = '0;
    tick(); tick();
    check("rst_outputs", {msg_ready, load_enable, input_complete, busy, done, input_data}, 0);
    check("rst_gap_outputs", {g_ready, g_le, g_ic, g_busy, g_done, g_idata}, 0);
    reset = 1'b0;
    tick();
    check("ready_after_rst", {msg_ready, busy}, 2'b10);
    check("gap_ready_after_rst", {g_ready, g_busy}, 2'b10);

    // Default parameters: ramp 00..1F
    msg_data = ramp(8'h00); msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    check("t1_first_byte", {load_enable, input_data, busy, msg_ready}, {1'b1, 8'h00, 1'b1, 1'b0});
    bad = 0;
    for (int k = 0; k < 32; k++) begin
      if (!(load_enable === 1'b1 && input_data === 8'(k) && input_complete === 1'b0)) bad++;
      tick();
    end
    check("t1_byte_cycles_bad", bad, 0);
    check("t1_ic_33", {input_complete, load_enable, input_data, done}, {1'b1, 1'b0, 8'h00, 1'b0});
    tick();
    check("t1_ic_34", {input_complete, load_enable, done}, 3'b100);
    tick();
    check("t1_done_35", {done, input_complete, msg_ready, busy}, 4'b1001);
    tick();
    check("t1_ready_36", {msg_ready, done, busy}, 3'b100);

    // IDLE_GAP=2 instance, all-0xA5
    g_data = {32{8'hA5}}; g_valid = 1'b1;
    tick();
    g_valid = 1'b0;
    bad = 0; ov = 0; le_cnt = 0; done_at = -1;
    for (int c = 1; c <= 97; c++) begin
      exp_le   = (c <= 94) && ((c - 1) % 3 == 0);
      exp_ic   = (c == 95) || (c == 96);
      exp_done = (c == 97);
      if (g_le !== exp_le || g_ic !== exp_ic || g_done !== exp_done ||
          g_idata !== (exp_le ? 8'hA5 : 8'h00)) bad++;
      if (g_le && g_ic) ov++;
      if (g_le) le_cnt++;
      if (g_done && done_at < 0) done_at = c;
      tick();
    end
    check("t2_pattern_bad", bad, 0);
    check("t2_le_count", le_cnt, 32);
    check("t2_overlap", ov, 0);
    check("t2_done_at", done_at, 97);
    check("t2_ready_98", {g_ready, g_busy}, 2'b10);

    // Abort at byte 10
    msg_data = ramp(8'h10); msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("abort_byte10", {load_enable, input_data}, {1'b1, 8'h1A});
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_next_zero", {load_enable, input_complete, done, busy, input_data}, 0);
    check("abort_ready", msg_ready, 1'b1);
    ic_cnt = 0; done_cnt = 0; le_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      if (input_complete) ic_cnt++;
      if (done) done_cnt++;
      if (load_enable) le_cnt++;
      tick();
    end
    check("abort_no_tail", {ic_cnt[7:0], done_cnt[7:0], le_cnt[7:0]}, 0);

    // msg_valid held high over two messages
    msg_data = ramp(8'h20); msg_valid = 1'b1;
    tick();
    msg_data = ramp(8'h40);
    bytes.delete();
    first_b = -1; done_at = -1; done_cnt = 0; ov = 0;
    for (int c = 1; c <= 80; c++) begin
      if (load_enable) begin
        bytes.push_back(input_data);
        if (bytes.size() == 33 && first_b < 0) first_b = c;
      end
      if (load_enable && input_complete) ov++;
      if (done) begin
        done_cnt++;
        if (done_at < 0) done_at = c;
      end
      if (c == 37) msg_valid = 1'b0;
      tick();
    end
    bad = 0;
    foreach (bytes[i]) if (bytes[i] !== 8'(8'h20 + i)) bad++;
    check("b2b_le_count", bytes.size(), 64);
    check("b2b_bytes_bad", bad, 0);
    check("b2b_done_at", done_at, 35);
    check("b2b_second_first_byte", first_b, 37);
    check("b2b_done_count", done_cnt, 2);
    check("b2b_overlap", ov, 0);

    // Abort alongside acceptance is ignored; then reset at byte 20
    msg_data = ramp(8'h40); msg_valid = 1'b1; abort = 1'b1;
    tick();
    msg_valid = 1'b0; abort = 1'b0;
    check("abort_at_accept_ignored", {load_enable, input_data, busy}, {1'b1, 8'h40, 1'b1});
    for (int i = 0; i < 20; i++) tick();
    check("rst_byte20", {load_enable, input_data}, {1'b1, 8'h54});
    reset = 1'b1;
    tick();
    check("midrst_outputs", {msg_ready, load_enable, input_complete, busy, done, input_data}, 0);
    reset = 1'b0;
    tick();
    check("midrst_ready", {msg_ready, busy, load_enable}, 3'b100);
    msg_data = ramp(8'h80); msg_valid = 1'b1;
    tick();
    msg_valid = 1'b0;
    check("fresh_byte0", {load_enable, input_data}, {1'b1, 8'h80});
    tick();
    check("fresh_byte1", {load_enable, input_data}, {1'b1, 8'h81});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
